// File: rtl/cluster_expander.sv
// cluster_expander: rebuilds the 384-pad S-bit mask from a stream of
// encoded clusters (address, valid, count), one mask per frame.
// Completed masks are held in an output register with a valid/ack
// handshake. Frames that finish while the held mask is still unacknowledged
// are dropped and counted in a saturating counter.
//
// Build option: define EXPAND_CNT_EN to set adr_i..adr_i+cnt_i per cluster.
// Without it only the seed bit adr_i is set and cnt_i is ignored.
module cluster_expander #(
  parameter int MXKEYS     = 384,
  parameter int MXKEYBITS  = 9,
  parameter int MXCNTB     = 3,
  parameter int MXCLUSTERS = 16,
  parameter int MXDROPB    = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 vpf_i,
  input  logic [MXKEYBITS-1:0] adr_i,
  input  logic [MXCNTB-1:0]    cnt_i,
  input  logic                 frame_end_i,
  output logic [MXKEYS-1:0]    mask_o,
  output logic                 mask_valid_o,
  input  logic                 mask_ack_i,
  output logic [4:0]           nclusters_o,
  output logic                 overflow_o,
  output logic [MXDROPB-1:0]   drop_cnt_o
);

  localparam logic [4:0]         MAX_CLU  = 5'(MXCLUSTERS);
  localparam logic [MXDROPB-1:0] DROP_SAT = {MXDROPB{1'b1}};

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Range decode of one cluster into a pad mask. Bits past the last pad are
  // simply not represented, so a cluster near the top end is clipped.
  function automatic logic [MXKEYS-1:0] decode_cluster(
    input logic [MXKEYBITS-1:0] adr,
    input logic [MXCNTB-1:0]    cnt
  );
    logic [MXKEYS-1:0] m;
    int unsigned       lo;
    int unsigned       hi;
    m  = '0;
    lo = 32'(adr);
`ifdef EXPAND_CNT_EN
    hi = lo + 32'(cnt);
`else
    hi = lo + 32'(cnt & {MXCNTB{1'b0}});
`endif
    for (int i = 0; i < MXKEYS; i++) begin
      m[i] = ($unsigned(i) >= lo) && ($unsigned(i) <= hi);
    end
    return m;
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;

  logic [MXKEYS-1:0]   acc_r;
  logic [4:0]          clu_cnt_r;
  logic                ovf_acc_r;

  logic [MXKEYS-1:0]   mask_r;
  logic                mask_valid_r;
  logic [4:0]          nclusters_r;
  logic                overflow_r;
  logic [MXDROPB-1:0]  drop_cnt_r;

  logic                used_s;
  logic                clu_add_s;
  logic                ovf_add_s;
  logic [MXKEYS-1:0]   dec_s;
  logic [MXKEYS-1:0]   final_mask_s;
  logic [4:0]          final_cnt_s;
  logic                final_ovf_s;
  logic                out_free_s;
  logic                load_s;
  logic                drop_s;
  logic                release_s;

  // Cluster qualification, final frame values and handshake decisions.
  always_comb begin
    used_s       = 1'b0;
    clu_add_s    = 1'b0;
    ovf_add_s    = 1'b0;
    dec_s        = decode_cluster(adr_i, cnt_i);
    final_mask_s = acc_r;
    final_cnt_s  = clu_cnt_r;
    final_ovf_s  = ovf_acc_r;
    out_free_s   = (~mask_valid_r) | mask_ack_i;
    load_s       = 1'b0;
    drop_s       = 1'b0;
    release_s    = 1'b0;
    state_nxt_s  = state_r;

    // The encoder's "none" code and any address past the last pad fail here.
    if (vpf_i && (32'(adr_i) < 32'(MXKEYS))) begin
      used_s = 1'b1;
    end else begin
      used_s = 1'b0;
    end

    if (used_s && (clu_cnt_r < MAX_CLU)) begin
      clu_add_s = 1'b1;
    end else begin
      clu_add_s = 1'b0;
    end
    ovf_add_s = used_s & ~clu_add_s;

    // The cluster arriving with frame_end_i still belongs to the closing frame.
    if (clu_add_s) begin
      final_mask_s = acc_r | dec_s;
      final_cnt_s  = clu_cnt_r + 5'd1;
    end else begin
      final_mask_s = acc_r;
      final_cnt_s  = clu_cnt_r;
    end
    final_ovf_s = ovf_acc_r | ovf_add_s;

    // FLUSH lasts one cycle; a frame_end_i in FLUSH closes a new (short) frame.
    case (state_r)
      ACCUM: begin
        if (frame_end_i) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      FLUSH: begin
        if (frame_end_i) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      default: begin
        state_nxt_s = ACCUM;
      end
    endcase

    if (frame_end_i) begin
      load_s    = out_free_s;
      drop_s    = ~out_free_s;
      release_s = 1'b0;
    end else begin
      load_s    = 1'b0;
      drop_s    = 1'b0;
      release_s = mask_ack_i & mask_valid_r;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ACCUM;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Frame accumulator: collects clusters, clears whenever a frame closes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_r     <= '0;
      clu_cnt_r <= 5'd0;
      ovf_acc_r <= 1'b0;
    end else if (frame_end_i) begin
      acc_r     <= '0;
      clu_cnt_r <= 5'd0;
      ovf_acc_r <= 1'b0;
    end else begin
      acc_r     <= final_mask_s;
      clu_cnt_r <= final_cnt_s;
      ovf_acc_r <= final_ovf_s;
    end
  end

  // Output holding register with valid/ack handshake.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask_r       <= '0;
      mask_valid_r <= 1'b0;
      nclusters_r  <= 5'd0;
      overflow_r   <= 1'b0;
    end else if (load_s) begin
      mask_r       <= final_mask_s;
      mask_valid_r <= 1'b1;
      nclusters_r  <= final_cnt_s;
      overflow_r   <= final_ovf_s;
    end else if (release_s) begin
      mask_valid_r <= 1'b0;
    end
  end

  // Saturating count of frames discarded for backpressure.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_r <= '0;
    end else if (drop_s && (drop_cnt_r != DROP_SAT)) begin
      drop_cnt_r <= drop_cnt_r + {{(MXDROPB-1){1'b0}}, 1'b1};
    end
  end

  assign mask_o       = mask_r;
  assign mask_valid_o = mask_valid_r;
  assign nclusters_o  = nclusters_r;
  assign overflow_o   = overflow_r;
  assign drop_cnt_o   = drop_cnt_r;

endmodule

// File: tb/tb_cluster_expander.sv
// Self-checking bench for cluster_expander: a frame-level reference model
// (list of accepted clusters per frame, mask built at frame end) checked
// every cycle, plus directed scenarios with literal expectations.
module tb_cluster_expander;

  logic         clock;
  logic         reset_n;
  logic         vpf_i;
  logic [8:0]   adr_i;
  logic [2:0]   cnt_i;
  logic         frame_end_i;
  logic [383:0] mask_o;
  logic         mask_valid_o;
  logic         mask_ack_i;
  logic [4:0]   nclusters_o;
  logic         overflow_o;
  logic [7:0]   drop_cnt_o;

  int n_chk;
  int n_err;
  logic chk_en;

  cluster_expander dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .vpf_i        (vpf_i),
    .adr_i        (adr_i),
    .cnt_i        (cnt_i),
    .frame_end_i  (frame_end_i),
    .mask_o       (mask_o),
    .mask_valid_o (mask_valid_o),
    .mask_ack_i   (mask_ack_i),
    .nclusters_o  (nclusters_o),
    .overflow_o   (overflow_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  int           q_adr[$];
  int           q_cnt[$];
  logic [383:0] m_mask;
  logic         m_valid;
  logic [4:0]   m_ncl;
  logic         m_ovf;
  logic [7:0]   m_drop;

  // Mask of the first n accepted clusters of the current frame.
  function automatic logic [383:0] frame_mask(int n);
    logic [383:0] mk;
    int w;
    mk = '0;
    for (int i = 0; i < n; i++) begin
`ifdef EXPAND_CNT_EN
      w = q_cnt[i] + 1;
`else
      w = 1;
`endif
      for (int j = 0; j < w; j++) begin
        if (q_adr[i] + j < 384) mk[q_adr[i] + j] = 1'b1;
      end
    end
    return mk;
  endfunction

  // Model update: collect accepted clusters, resolve the frame on frame_end.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_mask  <= '0;
      m_valid <= 1'b0;
      m_ncl   <= 5'd0;
      m_ovf   <= 1'b0;
      m_drop  <= 8'd0;
      q_adr.delete();
      q_cnt.delete();
    end else begin
      if (vpf_i && adr_i < 9'd384) begin
        q_adr.push_back(int'(adr_i));
        q_cnt.push_back(int'(cnt_i));
      end
      if (frame_end_i) begin
        if (!m_valid || mask_ack_i) begin
          m_mask  <= frame_mask((q_adr.size() > 16) ? 16 : q_adr.size());
          m_ncl   <= 5'((q_adr.size() > 16) ? 16 : q_adr.size());
          m_ovf   <= (q_adr.size() > 16);
          m_valid <= 1'b1;
        end else if (m_drop != 8'hFF) begin
          m_drop <= m_drop + 8'd1;
        end
        q_adr.delete();
        q_cnt.delete();
      end else if (mask_ack_i && m_valid) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("mask_o", mask_o, m_mask);
      chk("mask_valid_o", 384'(mask_valid_o), 384'(m_valid));
      chk("nclusters_o", 384'(nclusters_o), 384'(m_ncl));
      chk("overflow_o", 384'(overflow_o), 384'(m_ovf));
      chk("drop_cnt_o", 384'(drop_cnt_o), 384'(m_drop));
    end
  end

  // Apply one cycle of inputs; returns 1 time unit after the consuming edge.
  task automatic drive(input logic v, input int a, input int c, input logic fe, input logic ack);
    vpf_i       = v;
    adr_i       = 9'(a);
    cnt_i       = 3'(c);
    frame_end_i = fe;
    mask_ack_i  = ack;
    @(posedge clock);
    #1;
  endtask

  logic [383:0] e;

  initial begin
    n_chk = 0;
    n_err = 0;
    chk_en = 1'b0;
    reset_n = 1'b1;
    vpf_i = 1'b0;
    adr_i = 9'd0;
    cnt_i = 3'd0;
    frame_end_i = 1'b0;
    mask_ack_i = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk_en = 1'b1;
    @(posedge clock);
    #1;
    chk("reset mask_valid", 384'(mask_valid_o), 384'd0);
    chk("reset mask", mask_o, 384'd0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock);
    #1;

    // single cluster adr=5 cnt=2 with frame_end in the same cycle
    drive(1'b1, 5, 2, 1'b1, 1'b0);
    e = '0;
    e[5] = 1'b1;
`ifdef EXPAND_CNT_EN
    e[6] = 1'b1;
    e[7] = 1'b1;
`endif
    chk("single valid", 384'(mask_valid_o), 384'd1);
    chk("single mask", mask_o, e);
    chk("single ncl", 384'(nclusters_o), 384'd1);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    chk("ack clears valid", 384'(mask_valid_o), 384'd0);
    chk("ack keeps mask", mask_o, e);

    // top-edge clipping and the "none" address
    drive(1'b1, 381, 7, 1'b0, 1'b0);
    drive(1'b1, 511, 3, 1'b1, 1'b0);
    e = '0;
    e[381] = 1'b1;
`ifdef EXPAND_CNT_EN
    e[382] = 1'b1;
    e[383] = 1'b1;
`endif
    chk("clip mask", mask_o, e);
    chk("clip ncl", 384'(nclusters_o), 384'd1);
    chk("clip ovf", 384'(overflow_o), 384'd0);
    drive(1'b0, 0, 0, 1'b0, 1'b1);

    // 18 clusters: only the first 16 land
    for (int k = 0; k < 18; k++) drive(1'b1, 20 * k, 0, 1'b0, 1'b0);
    drive(1'b0, 0, 0, 1'b1, 1'b0);
    e = '0;
    for (int k = 0; k < 16; k++) e[20 * k] = 1'b1;
    chk("ovf mask", mask_o, e);
    chk("ovf ncl", 384'(nclusters_o), 384'd16);
    chk("ovf flag", 384'(overflow_o), 384'd1);
    drive(1'b0, 0, 0, 1'b0, 1'b1);

    // three frame ends without ack: one emitted, two dropped
    drive(1'b1, 10, 0, 1'b1, 1'b0);
    drive(1'b1, 11, 0, 1'b1, 1'b0);
    drive(1'b1, 12, 0, 1'b1, 1'b0);
    e = '0;
    e[10] = 1'b1;
    chk("bp mask", mask_o, e);
    chk("bp drop", 384'(drop_cnt_o), 384'd2);
    chk("bp valid", 384'(mask_valid_o), 384'd1);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    chk("bp ack", 384'(mask_valid_o), 384'd0);

    // frame_end together with ack while valid: new mask loads
    drive(1'b1, 50, 0, 1'b1, 1'b0);
    drive(1'b1, 60, 0, 1'b1, 1'b1);
    e = '0;
    e[60] = 1'b1;
    chk("fe+ack mask", mask_o, e);
    chk("fe+ack valid", 384'(mask_valid_o), 384'd1);
    chk("fe+ack drop", 384'(drop_cnt_o), 384'd2);
    drive(1'b0, 0, 0, 1'b0, 1'b1);

    // asynchronous reset mid-frame
    drive(1'b1, 100, 1, 1'b0, 1'b0);
    drive(1'b1, 110, 1, 1'b0, 1'b0);
    vpf_i = 1'b1;
    adr_i = 9'd120;
    #3 reset_n = 1'b0;
    vpf_i = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock);
    #1;
    drive(1'b0, 0, 0, 1'b1, 1'b0);
    chk("rst mask", mask_o, 384'd0);
    chk("rst ncl", 384'(nclusters_o), 384'd0);
    chk("rst drop", 384'(drop_cnt_o), 384'd0);
    chk("rst valid", 384'(mask_valid_o), 384'd1);

    // randomized traffic, three mixes
    for (int n = 0; n < 3000; n++) begin
      int r;
      int a;
      r = $urandom_range(0, 9);
      a = (r == 0) ? 511 : (r == 1) ? $urandom_range(370, 511) : $urandom_range(0, 383);
      drive($urandom_range(0, 1) == 1, a, $urandom_range(0, 7),
            $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
    end
    for (int n = 0; n < 2000; n++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 383), $urandom_range(0, 7),
            $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
    end
    chk("drop saturates", 384'(drop_cnt_o), 384'd255);
    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 400), $urandom_range(0, 7),
            $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
